// File: rtl/id_stage_hazard_if.sv
// IF <-> ID <-> ID/EX signal bundle for id_stage_hazard.
// master = IF/pipeline side driving the stage, slave = the decode stage.
interface id_stage_hazard_if #(
    parameter int unsigned DATA_W = 32
);
    logic              i_valid;
    logic [31:0]       i_next_pc;
    logic [31:0]       i_instruction;
    logic              i_hold;
    logic              i_reg_write;
    logic [4:0]        i_write_register;
    logic [DATA_W-1:0] i_write_data;
    logic              i_ex_reg_write;
    logic              i_ex_mem_read;
    logic [4:0]        i_ex_rd;
    logic              i_mem_reg_write;
    logic              i_mem_mem_read;
    logic [4:0]        i_mem_rd;
    logic [DATA_W-1:0] i_mem_result;

    logic              o_stall;
    logic              o_take_branch;
    logic [31:0]       o_branch_target_addr;
    logic              o_valid;
    logic [DATA_W-1:0] o_read_data_1;
    logic [DATA_W-1:0] o_read_data_2;
    logic [DATA_W-1:0] o_sign_extended_imm;
    logic [4:0]        o_rs;
    logic [4:0]        o_rt;
    logic [4:0]        o_rd;
    logic [DATA_W-1:0] o_shamt;
    logic [5:0]        o_function;
    logic [5:0]        o_opcode;
    logic [31:0]       o_link_pc;
    logic [1:0]        o_alu_src_a;
    logic              o_alu_src_b;
    logic              o_reg_dst;
    logic              o_reg_write;
    logic              o_mem_read;
    logic              o_mem_write;
    logic              o_mem_to_reg;
    logic [31:0]       o_stall_count;
    logic [31:0]       o_branch_count;

    modport master (
        output i_valid, i_next_pc, i_instruction, i_hold,
               i_reg_write, i_write_register, i_write_data,
               i_ex_reg_write, i_ex_mem_read, i_ex_rd,
               i_mem_reg_write, i_mem_mem_read, i_mem_rd, i_mem_result,
        input  o_stall, o_take_branch, o_branch_target_addr, o_valid,
               o_read_data_1, o_read_data_2, o_sign_extended_imm,
               o_rs, o_rt, o_rd, o_shamt, o_function, o_opcode, o_link_pc,
               o_alu_src_a, o_alu_src_b, o_reg_dst, o_reg_write,
               o_mem_read, o_mem_write, o_mem_to_reg,
               o_stall_count, o_branch_count
    );

    modport slave (
        input  i_valid, i_next_pc, i_instruction, i_hold,
               i_reg_write, i_write_register, i_write_data,
               i_ex_reg_write, i_ex_mem_read, i_ex_rd,
               i_mem_reg_write, i_mem_mem_read, i_mem_rd, i_mem_result,
        output o_stall, o_take_branch, o_branch_target_addr, o_valid,
               o_read_data_1, o_read_data_2, o_sign_extended_imm,
               o_rs, o_rt, o_rd, o_shamt, o_function, o_opcode, o_link_pc,
               o_alu_src_a, o_alu_src_b, o_reg_dst, o_reg_write,
               o_mem_read, o_mem_write, o_mem_to_reg,
               o_stall_count, o_branch_count
    );
endinterface

// File: rtl/id_stage_hazard.sv
// MIPS32 decode stage: regfile, MEM forwarding, hazard stall, branch resolve, ID/EX register.
// Define ID_PERF_CNT_EN to build the saturating stall/branch counters.
module id_stage_hazard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned LINK_REG = 31
) (
    input logic           clk,
    input logic           reset,
    id_stage_hazard_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] shamt;
        logic [5:0]        funct;
        logic [5:0]        opcode;
        logic [31:0]       link_pc;
        logic [1:0]        alu_src_a;
        logic              alu_src_b;
        logic              reg_dst;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } idex_t;

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd_field, shamt;
    logic [15:0] imm16;
    assign opcode   = bus.i_instruction[31:26];
    assign rs       = bus.i_instruction[25:21];
    assign rt       = bus.i_instruction[20:16];
    assign rd_field = bus.i_instruction[15:11];
    assign shamt    = bus.i_instruction[10:6];
    assign funct    = bus.i_instruction[5:0];
    assign imm16    = bus.i_instruction[15:0];

    // Instruction decode into control fields and source usage
    logic       uses_rs, uses_rt, is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
    logic       reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, alu_src_b_d, reg_dst_d;
    logic [1:0] alu_src_a_d;
    always_comb begin
        uses_rs = 1'b0; uses_rt = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_jalr = 1'b0;
        reg_write_d = 1'b0; mem_read_d = 1'b0; mem_write_d = 1'b0; mem_to_reg_d = 1'b0;
        alu_src_b_d = 1'b0; reg_dst_d = 1'b0; alu_src_a_d = 2'd0;
        case (opcode)
            OP_RTYPE: begin
                uses_rs = 1'b1; uses_rt = 1'b1; reg_write_d = 1'b1; reg_dst_d = 1'b1;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        uses_rs = 1'b0; alu_src_a_d = 2'd1;
                    end
                    FN_JR: begin
                        is_jr = 1'b1; uses_rt = 1'b0; reg_write_d = 1'b0; reg_dst_d = 1'b0;
                    end
                    FN_JALR: begin
                        is_jalr = 1'b1; uses_rt = 1'b0; alu_src_a_d = 2'd2;
                    end
                    default: ;
                endcase
            end
            OP_J:   is_j = 1'b1;
            OP_JAL: begin
                is_jal = 1'b1; reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_src_a_d = 2'd2;
            end
            OP_BEQ: begin is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BNE: begin is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                uses_rs = 1'b1; reg_write_d = 1'b1; alu_src_b_d = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                uses_rs = 1'b1; reg_write_d = 1'b1; mem_read_d = 1'b1;
                mem_to_reg_d = 1'b1; alu_src_b_d = 1'b1;
            end
            6'h28, 6'h29, 6'h2b: begin
                uses_rs = 1'b1; uses_rt = 1'b1; mem_write_d = 1'b1; alu_src_b_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Write-first regfile read; out-of-range and GPR0 read as zero
    logic              rs_ok, rt_ok;
    logic [DATA_W-1:0] rf_rs, rf_rt, op_a, op_b;
    assign rs_ok = (rs != 5'd0) && ({1'b0, rs} < 6'(NUM_REGS));
    assign rt_ok = (rt != 5'd0) && ({1'b0, rt} < 6'(NUM_REGS));
    always_comb begin
        rf_rs = '0;
        rf_rt = '0;
        if (rs_ok) rf_rs = (bus.i_reg_write && bus.i_write_register == rs) ? bus.i_write_data : rf[rs];
        if (rt_ok) rf_rt = (bus.i_reg_write && bus.i_write_register == rt) ? bus.i_write_data : rf[rt];
    end

    logic mem_fwd_ok;
    assign mem_fwd_ok = bus.i_mem_reg_write && !bus.i_mem_mem_read;
    assign op_a = (mem_fwd_ok && rs != 5'd0 && bus.i_mem_rd == rs) ? bus.i_mem_result : rf_rs;
    assign op_b = (mem_fwd_ok && rt != 5'd0 && bus.i_mem_rd == rt) ? bus.i_mem_result : rf_rt;

    // Hazards: load-use on any source, and late operands for ID-resolved branches
    logic br_rs, br_rt, load_use, br_haz, hazard, stall, take;
    assign br_rs = is_beq | is_bne | is_jr | is_jalr;
    assign br_rt = is_beq | is_bne;
    assign load_use = bus.i_ex_mem_read &&
                      ((uses_rs && rs != 5'd0 && bus.i_ex_rd == rs) ||
                       (uses_rt && rt != 5'd0 && bus.i_ex_rd == rt));
    assign br_haz = (br_rs && rs != 5'd0 &&
                     ((bus.i_ex_reg_write && bus.i_ex_rd == rs) ||
                      (bus.i_mem_mem_read && bus.i_mem_rd == rs))) ||
                    (br_rt && rt != 5'd0 &&
                     ((bus.i_ex_reg_write && bus.i_ex_rd == rt) ||
                      (bus.i_mem_mem_read && bus.i_mem_rd == rt)));
    assign hazard = bus.i_valid && (load_use || br_haz);
    assign stall  = bus.i_hold || hazard;
    assign take   = bus.i_valid && !stall &&
                    ((is_beq && op_a == op_b) || (is_bne && op_a != op_b) ||
                     is_j || is_jal || is_jr || is_jalr);

    logic [31:0] target;
    always_comb begin
        target = 32'd0;
        if (is_beq || is_bne)     target = bus.i_next_pc + {{14{imm16[15]}}, imm16, 2'b00};
        else if (is_j || is_jal)  target = {bus.i_next_pc[31:28], bus.i_instruction[25:0], 2'b00};
        else if (is_jr || is_jalr) target = op_a[31:0];
    end

    assign bus.o_stall              = stall;
    assign bus.o_take_branch        = take;
    assign bus.o_branch_target_addr = target;

    // Next ID/EX contents; side-effecting controls only for real instructions
    idex_t idex_d, idex_q;
    always_comb begin
        idex_d            = '0;
        idex_d.valid      = bus.i_valid;
        idex_d.rd1        = op_a;
        idex_d.rd2        = op_b;
        idex_d.imm        = {{(DATA_W-16){imm16[15]}}, imm16};
        idex_d.rs         = rs;
        idex_d.rt         = rt;
        idex_d.rd         = is_jal ? 5'(LINK_REG) : rd_field;
        idex_d.shamt      = {{(DATA_W-5){1'b0}}, shamt};
        idex_d.funct      = funct;
        idex_d.opcode     = opcode;
        idex_d.link_pc    = bus.i_next_pc;
        idex_d.alu_src_a  = alu_src_a_d;
        idex_d.alu_src_b  = alu_src_b_d;
        idex_d.reg_dst    = reg_dst_d;
        idex_d.reg_write  = reg_write_d & bus.i_valid;
        idex_d.mem_read   = mem_read_d & bus.i_valid;
        idex_d.mem_write  = mem_write_d & bus.i_valid;
        idex_d.mem_to_reg = mem_to_reg_d & bus.i_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) rf[i] <= '0;
        end else if (bus.i_reg_write && bus.i_write_register != 5'd0 &&
                     ({1'b0, bus.i_write_register} < 6'(NUM_REGS))) begin
            rf[bus.i_write_register] <= bus.i_write_data;
        end
    end

    // ID/EX: hold freezes, hazard inserts an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset)            idex_q <= '0;
        else if (!bus.i_hold) idex_q <= hazard ? '0 : idex_d;
    end

    assign bus.o_valid             = idex_q.valid;
    assign bus.o_read_data_1       = idex_q.rd1;
    assign bus.o_read_data_2       = idex_q.rd2;
    assign bus.o_sign_extended_imm = idex_q.imm;
    assign bus.o_rs                = idex_q.rs;
    assign bus.o_rt                = idex_q.rt;
    assign bus.o_rd                = idex_q.rd;
    assign bus.o_shamt             = idex_q.shamt;
    assign bus.o_function          = idex_q.funct;
    assign bus.o_opcode            = idex_q.opcode;
    assign bus.o_link_pc           = idex_q.link_pc;
    assign bus.o_alu_src_a         = idex_q.alu_src_a;
    assign bus.o_alu_src_b         = idex_q.alu_src_b;
    assign bus.o_reg_dst           = idex_q.reg_dst;
    assign bus.o_reg_write         = idex_q.reg_write;
    assign bus.o_mem_read          = idex_q.mem_read;
    assign bus.o_mem_write         = idex_q.mem_write;
    assign bus.o_mem_to_reg        = idex_q.mem_to_reg;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt, branch_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= 32'd0;
            branch_cnt <= 32'd0;
        end else begin
            if (hazard && stall_cnt != 32'hFFFF_FFFF)  stall_cnt  <= stall_cnt + 32'd1;
            if (take && branch_cnt != 32'hFFFF_FFFF)   branch_cnt <= branch_cnt + 32'd1;
        end
    end
    assign bus.o_stall_count  = stall_cnt;
    assign bus.o_branch_count = branch_cnt;
`else
    assign bus.o_stall_count  = 32'd0;
    assign bus.o_branch_count = 32'd0;
`endif
endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed bench for id_stage_hazard: ID/EX results go through a scoreboard queue,
// combinational stall/redirect outputs are checked inline.
module tb_id_stage_hazard;
    logic clk = 1'b0;
    logic reset;
    logic held = 1'b0;
    always #5 clk = ~clk;

    id_stage_hazard_if #(.DATA_W(32)) bus ();
    id_stage_hazard dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] rd1, rd2, imm, link_pc;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  opcode;
        logic        reg_write, mem_read, mem_write, alu_src_b;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction
    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push(input string name, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] link,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [5:0] op, input logic rw, input logic mr,
                        input logic mw, input logic asb);
        exp_t x;
        x.name = name; x.rd1 = rd1; x.rd2 = rd2; x.imm = imm; x.link_pc = link;
        x.rs = s; x.rt = t; x.rd = d; x.opcode = op;
        x.reg_write = rw; x.mem_read = mr; x.mem_write = mw; x.alu_src_b = asb;
        q.push_back(x);
    endtask

    task automatic idle();
        bus.i_valid = 1'b0; bus.i_next_pc = 32'd0; bus.i_instruction = 32'd0; bus.i_hold = 1'b0;
        bus.i_reg_write = 1'b0; bus.i_write_register = 5'd0; bus.i_write_data = 32'd0;
        bus.i_ex_reg_write = 1'b0; bus.i_ex_mem_read = 1'b0; bus.i_ex_rd = 5'd0;
        bus.i_mem_reg_write = 1'b0; bus.i_mem_mem_read = 1'b0; bus.i_mem_rd = 5'd0;
        bus.i_mem_result = 32'd0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] npc);
        bus.i_valid = 1'b1; bus.i_instruction = instr; bus.i_next_pc = npc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) held <= bus.i_hold;

    // Monitor: every newly loaded valid ID/EX entry must match the queue head
    always @(negedge clk) begin
        if (!reset && bus.o_valid && !held) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL idex_unexpected: got valid entry opcode=%h rd=%0d, want none",
                         bus.o_opcode, bus.o_rd);
            end else begin
                e = q.pop_front();
                if (bus.o_read_data_1 !== e.rd1 || bus.o_read_data_2 !== e.rd2 ||
                    bus.o_sign_extended_imm !== e.imm || bus.o_link_pc !== e.link_pc ||
                    bus.o_rs !== e.rs || bus.o_rt !== e.rt || bus.o_rd !== e.rd ||
                    bus.o_opcode !== e.opcode || bus.o_reg_write !== e.reg_write ||
                    bus.o_mem_read !== e.mem_read || bus.o_mem_write !== e.mem_write ||
                    bus.o_alu_src_b !== e.alu_src_b) begin
                    fails++;
                    $display("FAIL %s: got rd1=%h rd2=%h imm=%h link=%h rs=%0d rt=%0d rd=%0d op=%h rw=%b mr=%b mw=%b asb=%b, want rd1=%h rd2=%h imm=%h link=%h rs=%0d rt=%0d rd=%0d op=%h rw=%b mr=%b mw=%b asb=%b",
                             e.name, bus.o_read_data_1, bus.o_read_data_2, bus.o_sign_extended_imm,
                             bus.o_link_pc, bus.o_rs, bus.o_rt, bus.o_rd, bus.o_opcode,
                             bus.o_reg_write, bus.o_mem_read, bus.o_mem_write, bus.o_alu_src_b,
                             e.rd1, e.rd2, e.imm, e.link_pc, e.rs, e.rt, e.rd, e.opcode,
                             e.reg_write, e.mem_read, e.mem_write, e.alu_src_b);
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_sc, exp_bc, npc;
        logic [4:0]  r;
        reset = 1'b1;
        idle();
        step(); step();
        chk("reset_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_reg_write", 32'(bus.o_reg_write), 32'd0);
        chk("reset_stall", 32'(bus.o_stall), 32'd0);
        chk("reset_take", 32'(bus.o_take_branch), 32'd0);
        reset = 1'b0;

        // addi $1,$0,5
        idle(); issue(itype(6'h08, 5'd0, 5'd1, 16'd5), 32'h4);
        #1 chk("t1_stall", 32'(bus.o_stall), 32'd0);
        push("t1_addi", 32'd0, 32'd0, 32'd5, 32'h4, 5'd0, 5'd1, 5'd0, 6'h08, 1'b1, 1'b0, 1'b0, 1'b1);
        step();

        // add $3,$2,$2 with same-cycle WB of $2
        idle(); issue(rtype(5'd2, 5'd2, 5'd3, 6'h20), 32'h8);
        bus.i_reg_write = 1'b1; bus.i_write_register = 5'd2; bus.i_write_data = 32'h1234;
        push("t2_wb_bypass", 32'h1234, 32'h1234, 32'h1820, 32'h8, 5'd2, 5'd2, 5'd3, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // add $7,$2,$0 reads committed $2; WB preloads $4
        idle(); issue(rtype(5'd2, 5'd0, 5'd7, 6'h20), 32'hC);
        bus.i_reg_write = 1'b1; bus.i_write_register = 5'd4; bus.i_write_data = 32'h4444;
        push("t2_regfile_commit", 32'h1234, 32'd0, 32'h3820, 32'hC, 5'd2, 5'd0, 5'd7, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // load-use: lw $4 in EX, add $5,$4,$4 in ID
        idle(); issue(rtype(5'd4, 5'd4, 5'd5, 6'h20), 32'h10);
        bus.i_ex_reg_write = 1'b1; bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = 5'd4;
        #1 chk("t3_stall", 32'(bus.o_stall), 32'd1);
        step();
        chk("t3_bubble", 32'(bus.o_valid), 32'd0);
        idle(); issue(rtype(5'd4, 5'd4, 5'd5, 6'h20), 32'h10);
        bus.i_mem_reg_write = 1'b1; bus.i_mem_mem_read = 1'b1; bus.i_mem_rd = 5'd4;
        bus.i_mem_result = 32'hDEAD;
        #1 chk("t3_release", 32'(bus.o_stall), 32'd0);
        push("t3_load_use", 32'h4444, 32'h4444, 32'h2820, 32'h10, 5'd4, 5'd4, 5'd5, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // beq $6,$6,+3 behind an ALU write of $6
        idle(); issue(itype(6'h04, 5'd6, 5'd6, 16'd3), 32'h104);
        bus.i_ex_reg_write = 1'b1; bus.i_ex_rd = 5'd6;
        #1 chk("t4_stall", 32'(bus.o_stall), 32'd1);
        chk("t4_no_take", 32'(bus.o_take_branch), 32'd0);
        step();
        chk("t4_bubble", 32'(bus.o_valid), 32'd0);
        idle(); issue(itype(6'h04, 5'd6, 5'd6, 16'd3), 32'h104);
        bus.i_mem_reg_write = 1'b1; bus.i_mem_rd = 5'd6; bus.i_mem_result = 32'h77;
        #1 chk("t4_stall_rel", 32'(bus.o_stall), 32'd0);
        chk("t4_take", 32'(bus.o_take_branch), 32'd1);
        chk("t4_target", bus.o_branch_target_addr, 32'h110);
        push("t4_beq", 32'h77, 32'h77, 32'd3, 32'h104, 5'd6, 5'd6, 5'd0, 6'h04, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // three load -> bne rN,$0,-1 cases, two stall cycles each
        for (int k = 0; k < 3; k++) begin
            r   = 5'(8 + k);
            npc = 32'h204 + 32'(k) * 32'h100;
            idle(); issue(itype(6'h05, r, 5'd0, 16'hFFFF), npc);
            bus.i_ex_reg_write = 1'b1; bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = r;
            #1 chk("lb_stall_ex", 32'(bus.o_stall), 32'd1);
            step();
            idle(); issue(itype(6'h05, r, 5'd0, 16'hFFFF), npc);
            bus.i_mem_reg_write = 1'b1; bus.i_mem_mem_read = 1'b1; bus.i_mem_rd = r;
            bus.i_mem_result = 32'hBAD;
            #1 chk("lb_stall_mem", 32'(bus.o_stall), 32'd1);
            step();
            idle(); issue(itype(6'h05, r, 5'd0, 16'hFFFF), npc);
            bus.i_reg_write = 1'b1; bus.i_write_register = r; bus.i_write_data = 32'(9 + k);
            #1 chk("lb_stall_rel", 32'(bus.o_stall), 32'd0);
            chk("lb_take", 32'(bus.o_take_branch), 32'd1);
            chk("lb_target", bus.o_branch_target_addr, npc - 32'd4);
            push("lb_bne", 32'(9 + k), 32'd0, 32'hFFFF_FFFF, npc, r, 5'd0, 5'd31, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end

        // bne $2,$2,+1 not taken
        idle(); issue(itype(6'h05, 5'd2, 5'd2, 16'd1), 32'h500);
        #1 chk("bne_nt_take", 32'(bus.o_take_branch), 32'd0);
        chk("bne_nt_target", bus.o_branch_target_addr, 32'h504);
        push("bne_nt", 32'h1234, 32'h1234, 32'd1, 32'h500, 5'd2, 5'd2, 5'd0, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // jr $1 with $1 forwarded from MEM
        idle(); issue(rtype(5'd1, 5'd0, 5'd0, 6'h08), 32'h3004);
        bus.i_mem_reg_write = 1'b1; bus.i_mem_rd = 5'd1; bus.i_mem_result = 32'h3000;
        #1 chk("jr_take", 32'(bus.o_take_branch), 32'd1);
        chk("jr_target", bus.o_branch_target_addr, 32'h3000);
        push("jr", 32'h3000, 32'd0, 32'h8, 32'h3004, 5'd1, 5'd0, 5'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // jal 0x40
        idle(); issue({6'h03, 26'h40}, 32'h2004);
        #1 chk("jal_take", 32'(bus.o_take_branch), 32'd1);
        chk("jal_target", bus.o_branch_target_addr, 32'h100);
        push("jal", 32'd0, 32'd0, 32'h40, 32'h2004, 5'd0, 5'd0, 5'd31, 6'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // hold for 3 cycles with a jump waiting in ID
        idle(); issue({6'h02, 26'h80}, 32'h3000); bus.i_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_stall", 32'(bus.o_stall), 32'd1);
            chk("hold_no_take", 32'(bus.o_take_branch), 32'd0);
            step();
            chk("hold_rd", 32'(bus.o_rd), 32'd31);
            chk("hold_link", bus.o_link_pc, 32'h2004);
        end
        bus.i_hold = 1'b0;
        #1 chk("j_take", 32'(bus.o_take_branch), 32'd1);
        chk("j_target", bus.o_branch_target_addr, 32'h200);
        push("j", 32'd0, 32'd0, 32'h80, 32'h3000, 5'd0, 5'd0, 5'd0, 6'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        idle(); step(); step();
`ifdef ID_PERF_CNT_EN
        exp_sc = 32'd8; exp_bc = 32'd7;
`else
        exp_sc = 32'd0; exp_bc = 32'd0;
`endif
        chk("stall_count", bus.o_stall_count, exp_sc);
        chk("branch_count", bus.o_branch_count, exp_bc);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        // reset wins over hold
        bus.i_hold = 1'b1; reset = 1'b1;
        step();
        chk("rst_hold_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_hold_link", bus.o_link_pc, 32'd0);
        chk("rst_stall_count", bus.o_stall_count, 32'd0);
        reset = 1'b0; idle(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
